csr_exec_ctrl: RTL and testbench

Sequencing controller for CSR instructions in the kianv core. It accepts a decoded CSR request from the main control FSM, runs a fixed read-then-modify-write sequence against the counter CSRs (cycle/instret, mcycle/minstret) and an optional mscratch register, and returns the old CSR value to be written to rd. It owns the 64-bit counters and arbitrates between architectural writes and free-running increments.

---
 rtl/csr_exec_ctrl_pkg.sv | 26 ++
 rtl/csr_exec_ctrl_if.sv | 15 +
 rtl/csr_exec_ctrl_counter64.sv | 23 ++
 rtl/csr_exec_ctrl.sv | 111 +++++++++++
 tb/tb_csr_exec_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_exec_ctrl_pkg.sv
// csr_exec_ctrl_pkg: shared CSR opcodes, CSR addresses, FSM states and the read-modify-write helper.
package csr_exec_ctrl_pkg;
  typedef enum logic [2:0] {
    CSR_OP_NA     = 3'b000,
    CSR_OP_CSRRW  = 3'b001,
    CSR_OP_CSRRS  = 3'b010,
    CSR_OP_CSRRC  = 3'b011,
    CSR_OP_CSRRWI = 3'b101,
    CSR_OP_CSRRSI = 3'b110,
    CSR_OP_CSRRCI = 3'b111
  } csr_op_t;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  typedef enum logic [1:0] {IDLE, READ, WRITE} csr_state_t;
  // funct3[1:0]: 01 write, 10 set, 11 clear; 00 is not a CSR op
  function automatic logic [31:0] csr_new(input logic [1:0] op, input logic [31:0] old, input logic [31:0] opnd);
    return op == 2'b01 ? opnd : op == 2'b10 ? (old | opnd) : (old & ~opnd);
  endfunction
endpackage

// File: rtl/csr_exec_ctrl_if.sv
// csr_exec_ctrl_if: request/response bus between the control FSM (master) and the CSR unit (slave).
//   csr_valid/funct3/csr_addr/rs1_data/rs1_uimm: request, held until csr_ready
//   csr_ready/rd_data/illegal: one-cycle completion with old CSR value and illegal flag
interface csr_exec_ctrl_if;
  logic        csr_valid;
  logic        csr_ready;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_uimm;
  logic [31:0] rd_data;
  logic        illegal;
  modport master (output csr_valid, funct3, csr_addr, rs1_data, rs1_uimm, input csr_ready, rd_data, illegal);
  modport slave (input csr_valid, funct3, csr_addr, rs1_data, rs1_uimm, output csr_ready, rd_data, illegal);
endinterface

// File: rtl/csr_exec_ctrl_counter64.sv
// csr_counter64: wrapping counter whose 32-bit halves can be overwritten independently.
//   clk, resetn (sync, active-low); inc: count enable; wr_lo/wr_hi: replace low/high half with wdata;
//   cnt: counter value. A write beats that cycle's increment; the unwritten half holds, no carry.
module csr_counter64
  import csr_exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] cnt
);
  localparam int HW = WIDTH - 32;
  always_ff @(posedge clk) begin
    if (!resetn) cnt <= '0;
    else if (wr_lo || wr_hi) cnt <= {wr_hi ? wdata[HW-1:0] : cnt[WIDTH-1:32], wr_lo ? wdata : cnt[31:0]};
    else if (inc) cnt <= cnt + WIDTH'(1);
  end
endmodule

// File: rtl/csr_exec_ctrl.sv
// csr_exec_ctrl: IDLE->READ->WRITE sequencer for CSR instructions over the cycle/instret counters.
//   clk, resetn (sync, active-low); bus: csr_exec_ctrl_if.slave request/response; instr_retired: retire pulse.
//   Optional mscratch at 0x340 when KIANV_CSR_MSCRATCH_EN is defined; otherwise 0x340 is illegal.
module csr_exec_ctrl
  import csr_exec_ctrl_pkg::*;
#(
  parameter int          CNT_WIDTH      = 64,
  parameter logic [31:0] MSCRATCH_RESET = 32'h0
) (
  input logic             clk,
  input logic             resetn,
  csr_exec_ctrl_if.slave  bus,
  input logic             instr_retired
);
  csr_state_t state;
  logic [2:0]  f3_q;
  logic [11:0] addr_q;
  logic [31:0] opnd_q, old_q, new_q;
  logic [4:0]  uimm_q;
  logic        ill_q, commit_q;
  logic [CNT_WIDTH-1:0] cyc, ins;
  logic [31:0] old_val;
  logic        known, ro, op_ok, wen, bad, commit;
  logic        wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
`ifdef KIANV_CSR_MSCRATCH_EN
  logic [31:0] mscratch;
`endif
  always_comb begin
    known = 1'b1;
    old_val = '0;
    case (addr_q)
      CSR_CYCLE,    CSR_MCYCLE:    old_val = cyc[31:0];
      CSR_CYCLEH,   CSR_MCYCLEH:   old_val = 32'(cyc[CNT_WIDTH-1:32]);
      CSR_INSTRET,  CSR_MINSTRET:  old_val = ins[31:0];
      CSR_INSTRETH, CSR_MINSTRETH: old_val = 32'(ins[CNT_WIDTH-1:32]);
`ifdef KIANV_CSR_MSCRATCH_EN
      CSR_MSCRATCH:                old_val = mscratch;
`endif
      default:                     known = 1'b0;
    endcase
  end
  // Cxx is the user-level read-only window onto the counters
  assign ro = addr_q[11:8] == 4'hC;
  assign op_ok = f3_q[1:0] != 2'b00;
  // set/clear with x0 or zimm=0 is a pure read
  assign wen = op_ok && (f3_q[1:0] == 2'b01 || uimm_q != 5'd0);
  assign bad = !known || !op_ok;
  assign commit = state == WRITE && commit_q;
  assign wr_cyc_lo = commit && addr_q == CSR_MCYCLE;
  assign wr_cyc_hi = commit && addr_q == CSR_MCYCLEH;
  assign wr_ins_lo = commit && addr_q == CSR_MINSTRET;
  assign wr_ins_hi = commit && addr_q == CSR_MINSTRETH;
  csr_counter64 #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk(clk), .resetn(resetn), .inc(1'b1), .wr_lo(wr_cyc_lo), .wr_hi(wr_cyc_hi), .wdata(new_q), .cnt(cyc)
  );
  csr_counter64 #(.WIDTH(CNT_WIDTH)) u_instret (
    .clk(clk), .resetn(resetn), .inc(instr_retired), .wr_lo(wr_ins_lo), .wr_hi(wr_ins_hi), .wdata(new_q), .cnt(ins)
  );
`ifdef KIANV_CSR_MSCRATCH_EN
  always_ff @(posedge clk) begin
    if (!resetn) mscratch <= MSCRATCH_RESET;
    else if (commit && addr_q == CSR_MSCRATCH) mscratch <= new_q;
  end
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      bus.csr_ready <= 1'b0;
      bus.rd_data <= '0;
      bus.illegal <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      opnd_q <= '0;
      uimm_q <= '0;
      old_q <= '0;
      new_q <= '0;
      ill_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.csr_ready <= 1'b0;
          bus.rd_data <= '0;
          bus.illegal <= 1'b0;
          // a valid still held during the ready cycle belongs to the finished request
          if (bus.csr_valid && !bus.csr_ready) begin
            f3_q <= bus.funct3;
            addr_q <= bus.csr_addr;
            uimm_q <= bus.rs1_uimm;
            opnd_q <= bus.funct3[2] ? {27'b0, bus.rs1_uimm} : bus.rs1_data;
            state <= READ;
          end
        end
        READ: begin
          old_q <= bad ? '0 : old_val;
          new_q <= csr_new(f3_q[1:0], old_val, opnd_q);
          ill_q <= bad || (wen && ro);
          commit_q <= wen && !bad && !ro;
          state <= WRITE;
        end
        WRITE: begin
          bus.csr_ready <= 1'b1;
          bus.rd_data <= old_q;
          bus.illegal <= ill_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_exec_ctrl.sv
// tb_csr_exec_ctrl: directed self-checking bench for csr_exec_ctrl.
module tb_csr_exec_ctrl;
  import csr_exec_ctrl_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic instr_retired = 1'b0;
  csr_exec_ctrl_if bus();
  csr_exec_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus), .instr_retired(instr_retired));
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  int edge_cnt = 0, rst_edge = 0;
  logic [31:0] rd;
  logic ill;
  int acc, lat;
  // edge_cnt after the last edge with resetn low: the cycle counter is 0 there
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (!resetn) rst_edge <= edge_cnt + 1;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic do_csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] u, input logic ret_w);
    @(negedge clk);
    bus.csr_valid = 1'b1;
    bus.funct3 = f3;
    bus.csr_addr = a;
    bus.rs1_data = rs1;
    bus.rs1_uimm = u;
    @(posedge clk);
    #1;
    acc = edge_cnt;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      instr_retired = (k == 1) ? ret_w : 1'b0;
      if (bus.csr_ready) begin
        lat = k;
        break;
      end
    end
    rd = bus.rd_data;
    ill = bus.illegal;
    @(negedge clk);
    bus.csr_valid = 1'b0;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.csr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.csr_ready); end
    checks++; if (bus.illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
    checks++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd: got %h want 0", bus.rd_data); end
    resetn = 1'b1;
  endtask
  task automatic test_read_cycle();
    repeat (10) @(posedge clk);
    do_csr(3'b010, CSR_CYCLE, 32'hDEAD_BEEF, 5'd0, 1'b0);
    checks++; if (lat !== 2) begin fails++; $display("FAIL read_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'(acc - rst_edge)) begin fails++; $display("FAIL read_cycle: got %h want %h", rd, 32'(acc - rst_edge)); end
    checks++; if (ill !== 1'b0) begin fails++; $display("FAIL read_cycle_ill: got %b want 0", ill); end
  endtask
  task automatic test_carry();
    int w;
    do_csr(3'b001, CSR_MCYCLE, 32'hFFFF_FFFF, 5'd7, 1'b0);
    w = acc + 2;
    checks++; if (rd !== 32'(acc - rst_edge)) begin fails++; $display("FAIL carry_old: got %h want %h", rd, 32'(acc - rst_edge)); end
    do_csr(3'b010, CSR_CYCLEH, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h1) begin fails++; $display("FAIL carry_hi: got %h want 1", rd); end
    do_csr(3'b010, CSR_CYCLE, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'(acc - w - 1)) begin fails++; $display("FAIL carry_lo: got %h want %h", rd, 32'(acc - w - 1)); end
  endtask
  task automatic test_mcycleh();
    do_csr(3'b001, CSR_MCYCLEH, 32'h1234_5678, 5'd1, 1'b0);
    checks++; if (rd !== 32'h1) begin fails++; $display("FAIL mcycleh_old: got %h want 1", rd); end
    do_csr(3'b010, CSR_CYCLEH, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL mcycleh_new: got %h want 12345678", rd); end
  endtask
  task automatic test_instret();
    do_csr(3'b001, CSR_MINSTRET, 32'h1F, 5'd2, 1'b0);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL instret_init: got %h want 0", rd); end
    do_csr(3'b011, CSR_MINSTRET, 32'hF, 5'd3, 1'b1);
    checks++; if (rd !== 32'h1F) begin fails++; $display("FAIL rc_old: got %h want 1f", rd); end
    do_csr(3'b010, CSR_INSTRET, 32'hDEAD_BEEF, 5'd0, 1'b0);
    checks++; if (rd !== 32'h10) begin fails++; $display("FAIL rc_write_wins: got %h want 10", rd); end
    @(negedge clk);
    instr_retired = 1'b1;
    repeat (3) @(negedge clk);
    instr_retired = 1'b0;
    do_csr(3'b010, CSR_INSTRET, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h13) begin fails++; $display("FAIL instret_inc: got %h want 13", rd); end
    do_csr(3'b010, CSR_MINSTRETH, 32'h100, 5'd4, 1'b0);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL instreth_old: got %h want 0", rd); end
    do_csr(3'b010, CSR_INSTRETH, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h100) begin fails++; $display("FAIL instreth_set: got %h want 100", rd); end
    do_csr(3'b010, CSR_INSTRET, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h13) begin fails++; $display("FAIL instret_lo_kept: got %h want 13", rd); end
  endtask
  task automatic test_read_only();
    do_csr(3'b101, CSR_INSTRET, 32'h0, 5'd5, 1'b0);
    checks++; if (ill !== 1'b1) begin fails++; $display("FAIL rwi_ro_ill: got %b want 1", ill); end
    checks++; if (rd !== 32'h13) begin fails++; $display("FAIL rwi_ro_rd: got %h want 13", rd); end
    do_csr(3'b110, CSR_INSTRET, 32'h0, 5'd0, 1'b0);
    checks++; if (ill !== 1'b0) begin fails++; $display("FAIL rsi0_ro_ill: got %b want 0", ill); end
    checks++; if (rd !== 32'h13) begin fails++; $display("FAIL rsi0_ro_rd: got %h want 13", rd); end
    do_csr(3'b111, CSR_INSTRETH, 32'h0, 5'd1, 1'b0);
    checks++; if (ill !== 1'b1 || rd !== 32'h100) begin fails++; $display("FAIL rci_ro: got ill=%b rd=%h want ill=1 rd=100", ill, rd); end
  endtask
  task automatic test_illegal();
    do_csr(3'b001, 12'h7C0, 32'h1, 5'd1, 1'b0);
    checks++; if (ill !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL bad_addr: got ill=%b rd=%h want ill=1 rd=0", ill, rd); end
    do_csr(3'b000, CSR_MINSTRET, 32'h55, 5'd1, 1'b0);
    checks++; if (ill !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL f3_000: got ill=%b rd=%h want ill=1 rd=0", ill, rd); end
    do_csr(3'b100, CSR_MINSTRET, 32'h55, 5'd1, 1'b0);
    checks++; if (ill !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL f3_100: got ill=%b rd=%h want ill=1 rd=0", ill, rd); end
    do_csr(3'b010, CSR_MINSTRET, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h13) begin fails++; $display("FAIL illegal_no_write: got %h want 13", rd); end
  endtask
  task automatic test_mscratch();
`ifdef KIANV_CSR_MSCRATCH_EN
    do_csr(3'b010, CSR_MSCRATCH, 32'hA5, 5'd1, 1'b0);
    checks++; if (ill !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL mscratch_rs: got ill=%b rd=%h want ill=0 rd=0", ill, rd); end
    do_csr(3'b011, CSR_MSCRATCH, 32'h05, 5'd1, 1'b0);
    checks++; if (rd !== 32'hA5) begin fails++; $display("FAIL mscratch_rc: got %h want a5", rd); end
    do_csr(3'b010, CSR_MSCRATCH, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'hA0) begin fails++; $display("FAIL mscratch_val: got %h want a0", rd); end
`else
    do_csr(3'b010, CSR_MSCRATCH, 32'h0, 5'd0, 1'b0);
    checks++; if (ill !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL mscratch_absent: got ill=%b rd=%h want ill=1 rd=0", ill, rd); end
`endif
  endtask
  task automatic test_back_to_back();
    int r1 = -1, r2 = -1, dbl = 0;
    logic prev = 1'b0;
    @(negedge clk);
    bus.csr_valid = 1'b1;
    bus.funct3 = 3'b010;
    bus.csr_addr = CSR_CYCLE;
    bus.rs1_data = 32'h0;
    bus.rs1_uimm = 5'd0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.csr_ready) begin
        if (prev) dbl++;
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = bus.csr_ready;
    end
    @(negedge clk);
    bus.csr_valid = 1'b0;
    repeat (5) @(posedge clk);
    checks++; if (r1 < 0 || r2 - r1 !== 4) begin fails++; $display("FAIL b2b_spacing: got %0d want 4", r2 - r1); end
    checks++; if (dbl !== 0) begin fails++; $display("FAIL b2b_pulse_width: got %0d wide pulses want 0", dbl); end
  endtask
  task automatic test_reset_abort();
    logic seen = 1'b0;
    @(negedge clk);
    bus.csr_valid = 1'b1;
    bus.funct3 = 3'b001;
    bus.csr_addr = CSR_MINSTRET;
    bus.rs1_data = 32'h55;
    bus.rs1_uimm = 5'd1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    bus.csr_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= bus.csr_ready; end
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) begin @(posedge clk); #1; seen |= bus.csr_ready; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b want 0", seen); end
    do_csr(3'b010, CSR_INSTRET, 32'h0, 5'd0, 1'b0);
    checks++; if (lat !== 2 || rd !== 32'h0) begin fails++; $display("FAIL abort_instret: got lat=%0d rd=%h want lat=2 rd=0", lat, rd); end
    do_csr(3'b010, CSR_INSTRETH, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL abort_instreth: got %h want 0", rd); end
    do_csr(3'b010, CSR_CYCLEH, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL abort_cycleh: got %h want 0", rd); end
    do_csr(3'b010, CSR_CYCLE, 32'h0, 5'd0, 1'b0);
    checks++; if (rd !== 32'(acc - rst_edge)) begin fails++; $display("FAIL abort_cycle: got %h want %h", rd, 32'(acc - rst_edge)); end
  endtask
  initial begin
    bus.csr_valid = 1'b0;
    bus.funct3 = 3'b000;
    bus.csr_addr = 12'h0;
    bus.rs1_data = 32'h0;
    bus.rs1_uimm = 5'd0;
    test_reset();
    test_read_cycle();
    test_carry();
    test_mcycleh();
    test_instret();
    test_read_only();
    test_illegal();
    test_mscratch();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
